dmem_port_arbiter: RTL and testbench

//  Shares the single-ported data memory (byte-enabled, 64-bit words, 1-cycle registered read) between
//  the core load/store path and the coprocessor I/O port. Replaces the hard address/rden mux in core.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/arb_starve_counter.sv | 30 +++
 rtl/dmem_port_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  // Owner of the read that is in flight in the memory pipeline.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_COP  = 2'd2
  } owner_t;

  localparam int DMEM_WORD_BYTES = 8;
  localparam int DMEM_BYTE_OFF   = $clog2(DMEM_WORD_BYTES);

  // Counter width able to hold 0..limit. The minimum is one bit so that a limit of 0 still gives a legal vector.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles a coprocessor request has been denied.
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  localparam int CW          = starve_cnt_width(STARVE_LIMIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          waiting,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          limit_hit
);

  assign limit_hit = (cnt == CW'(STARVE_LIMIT));

  // Count denied cycles up to the limit; any grant or a dropped request restarts it.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (waiting && !limit_hit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the core load/store path and the coprocessor port.
// The core has priority until a coprocessor request has waited STARVE_LIMIT cycles.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N            = 64,
  parameter int AW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_req,
  input  logic                       core_we,
  input  logic [N-1:0]               core_addr,
  input  logic [N-1:0]               core_wdata,
  input  logic [DMEM_WORD_BYTES-1:0] core_byteen,
  output logic                       core_stall,
  output logic                       core_rvalid,
  output logic [N-1:0]               core_rdata,
  input  logic                       cop_req,
  input  logic                       cop_we,
  input  logic [14:0]                cop_addr,
  input  logic [N-1:0]               cop_wdata,
  input  logic [DMEM_WORD_BYTES-1:0] cop_byteen,
  output logic                       cop_gnt,
  output logic                       cop_rvalid,
  output logic [N-1:0]               cop_rdata,
  output logic [AW-1:0]              mem_addr,
  output logic [N-1:0]               mem_data,
  output logic [DMEM_WORD_BYTES-1:0] mem_byteen,
  output logic                       mem_wren,
  output logic                       mem_rden,
  input  logic [N-1:0]               mem_q
);

  localparam int CW = starve_cnt_width(STARVE_LIMIT);

  logic          core_gnt;
  logic          limit_hit;
  logic [CW-1:0] starve_cnt;
  logic          acc_we;
  logic          acc_rd;
  owner_t        rd_owner;

  // Word-address selection drops the byte offset and wraps anything above the memory size.
  logic [AW-1:0] core_word;
  logic [AW-1:0] cop_word;
  assign core_word = core_addr[AW+DMEM_BYTE_OFF-1:DMEM_BYTE_OFF];
  assign cop_word  = cop_addr[AW+DMEM_BYTE_OFF-1:DMEM_BYTE_OFF];

  logic unused_bits;
  assign unused_bits = ^{core_addr[N-1:AW+DMEM_BYTE_OFF], core_addr[DMEM_BYTE_OFF-1:0],
                         cop_addr[14:AW+DMEM_BYTE_OFF], cop_addr[DMEM_BYTE_OFF-1:0], starve_cnt};

  assign core_gnt   = core_req & ~(cop_req & limit_hit);
  assign cop_gnt    = cop_req & ~core_gnt;
  assign core_stall = core_req & ~core_gnt;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .waiting  (cop_req & ~cop_gnt),
    .clear    (cop_gnt | ~cop_req),
    .cnt      (starve_cnt),
    .limit_hit(limit_hit)
  );

  // Steer the granted requester onto the memory port; idle cycles park everything at zero.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    mem_addr   = '0;
    mem_data   = '0;
    mem_byteen = '0;
    acc_we     = 1'b0;
    acc_rd     = 1'b0;
    if (core_gnt) begin
      mem_addr   = core_word;
      mem_data   = core_wdata;
      acc_we     = core_we;
      acc_rd     = ~core_we;
      mem_byteen = core_we ? core_byteen : '1;
    end else if (cop_gnt) begin
      mem_addr   = cop_word;
      mem_data   = cop_wdata;
      acc_we     = cop_we;
      acc_rd     = ~cop_we;
      mem_byteen = cop_we ? cop_byteen : '1;
    end
  end

  // Strobes are masked while reset is low so no access reaches the memory during reset.
  assign mem_wren = acc_we & reset;
  assign mem_rden = acc_rd & reset;

  // Remember who owns the read now in the memory pipeline; the response appears next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner <= OWN_NONE;
    end else if (mem_rden) begin
      rd_owner <= core_gnt ? OWN_CORE : OWN_COP;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  assign core_rvalid = (rd_owner == OWN_CORE);
  assign cop_rvalid  = (rd_owner == OWN_COP);
  assign core_rdata  = mem_q;
  assign cop_rdata   = mem_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by constrained-random traffic,
// compared against a transaction-level model (shadow memory, pending-response slot, wait counter).
module tb_dmem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [63:0] core_addr, core_wdata;
  logic [7:0]  core_byteen;
  logic        cop_req, cop_we;
  logic [14:0] cop_addr;
  logic [63:0] cop_wdata;
  logic [7:0]  cop_byteen;
  logic [63:0] mem_q;

  logic        core_stall, core_rvalid, cop_gnt, cop_rvalid, mem_wren, mem_rden;
  logic [63:0] core_rdata, cop_rdata, mem_data;
  logic [7:0]  mem_addr, mem_byteen;

  logic        z_stall, z_gnt, z_wren, z_rden;
  logic        unused_z_crv, unused_z_prv;
  logic [63:0] unused_z_crd, unused_z_prd, unused_z_data;
  logic [7:0]  unused_z_addr, unused_z_be;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.N(64), .AW(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_byteen(core_byteen), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .cop_req(cop_req), .cop_we(cop_we), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
    .cop_byteen(cop_byteen), .cop_gnt(cop_gnt), .cop_rvalid(cop_rvalid), .cop_rdata(cop_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_byteen(mem_byteen),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  dmem_port_arbiter #(.N(64), .AW(8), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_byteen(core_byteen), .core_stall(z_stall), .core_rvalid(unused_z_crv), .core_rdata(unused_z_crd),
    .cop_req(cop_req), .cop_we(cop_we), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
    .cop_byteen(cop_byteen), .cop_gnt(z_gnt), .cop_rvalid(unused_z_prv), .cop_rdata(unused_z_prd),
    .mem_addr(unused_z_addr), .mem_data(unused_z_data), .mem_byteen(unused_z_be),
    .mem_wren(z_wren), .mem_rden(z_rden), .mem_q(mem_q)
  );

  // Behavioural data memory attached to the main instance: byte-enabled write, registered read.
  logic [63:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < 8; b++)
        if (mem_byteen[b]) tb_mem[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
    if (mem_rden) mem_q <= tb_mem[mem_addr];
  end

  // Reference model state.
  logic [63:0] shadow [256];
  int          starve;
  int          pend;        // 0 none, 1 core, 2 cop
  logic [63:0] pend_data;
  logic        last_egc, last_egp;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock: check combinational outputs, advance the model, check the response after the edge.
  task automatic cycle(input bit rst_after = 1'b0);
    logic        in_rst, egc, egp, ewe, erd;
    logic [7:0]  ca, pa;
    int          n_pend, n_starve;
    logic [63:0] n_data;
    #1;
    in_rst = !reset;
    egc = core_req && !(cop_req && (starve == LIMIT));
    egp = cop_req && !egc;
    ca  = core_addr[10:3];
    pa  = cop_addr[10:3];
    check("core_stall", core_stall, core_req && !egc);
    check("cop_gnt", cop_gnt, egp);
    check("lim0_cop_gnt", z_gnt, cop_req);
    check("lim0_core_stall", z_stall, core_req && cop_req);
    ewe = (egc && core_we) || (egp && cop_we);
    erd = (egc && !core_we) || (egp && !cop_we);
    if (in_rst) begin
      check("rst_wren", mem_wren, 1'b0);
      check("rst_rden", mem_rden, 1'b0);
      check("lim0_rst_wren", z_wren | z_rden, 1'b0);
    end else begin
      check("mem_wren", mem_wren, ewe);
      check("mem_rden", mem_rden, erd);
      if (egc) begin
        check("mem_addr_core", mem_addr, ca);
        check("mem_byteen_core", mem_byteen, core_we ? core_byteen : 8'hFF);
        if (core_we) check("mem_data_core", mem_data, core_wdata);
      end else if (egp) begin
        check("mem_addr_cop", mem_addr, pa);
        check("mem_byteen_cop", mem_byteen, cop_we ? cop_byteen : 8'hFF);
        if (cop_we) check("mem_data_cop", mem_data, cop_wdata);
      end else begin
        check("idle_addr", mem_addr, 8'h00);
        check("idle_byteen", mem_byteen, 8'h00);
      end
    end
    n_pend = 0;
    n_data = '0;
    if (!in_rst) begin
      if (egc && !core_we) begin n_pend = 1; n_data = shadow[ca]; end
      if (egc && core_we) shadow[ca] = merge(shadow[ca], core_wdata, core_byteen);
      if (egp && !cop_we) begin n_pend = 2; n_data = shadow[pa]; end
      if (egp && cop_we) shadow[pa] = merge(shadow[pa], cop_wdata, cop_byteen);
    end
    if (in_rst || egp || !cop_req) n_starve = 0;
    else n_starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    last_egc = egc;
    last_egp = egp;
    @(posedge clk);
    #1;
    if (rst_after) begin
      reset = 1'b0;
      #1;
      n_pend = 0;
      n_starve = 0;
    end
    pend = n_pend;
    pend_data = n_data;
    starve = n_starve;
    check("core_rvalid", core_rvalid, pend == 1);
    check("cop_rvalid", cop_rvalid, pend == 2);
    if (pend == 1) check("core_rdata", core_rdata, pend_data);
    if (pend == 2) check("cop_rdata", cop_rdata, pend_data);
  endtask

  task automatic idle();
    core_req = 1'b0;
    cop_req  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = {$urandom, $urandom};
      shadow[i] = tb_mem[i];
    end
    mem_q = '0;
    starve = 0; pend = 0; pend_data = '0; last_egc = 1'b0; last_egp = 1'b0;
    core_we = 1'b0; core_addr = '0; core_wdata = '0; core_byteen = '0;
    cop_we = 1'b0; cop_addr = '0; cop_wdata = '0; cop_byteen = '0;
    idle();
    reset = 1'b0;

    // Reset state, with a core read pending: no strobes, no response.
    #2;
    check("reset_core_rvalid", core_rvalid, 1'b0);
    check("reset_cop_rvalid", cop_rvalid, 1'b0);
    core_req = 1'b1; core_addr = 64'h18;
    cycle();
    cycle();
    idle();
    reset = 1'b1;
    cycle();

    // 1. Core load at 0x18.
    core_req = 1'b1; core_we = 1'b0; core_addr = 64'h18;
    #1;
    check("t1_mem_addr", mem_addr, 8'd3);
    check("t1_stall", core_stall, 1'b0);
    cycle();
    idle();
    cycle();

    // 2. Coprocessor partial write at 0x20.
    cop_req = 1'b1; cop_we = 1'b1; cop_addr = 15'h20; cop_wdata = 64'h5A5A; cop_byteen = 8'h0F;
    #1;
    check("t2_cop_gnt", cop_gnt, 1'b1);
    check("t2_byteen", mem_byteen, 8'h0F);
    cycle();
    idle();
    // Read back from the core side: must see the merged word.
    core_req = 1'b1; core_we = 1'b0; core_addr = 64'h20;
    cycle();
    idle();
    cycle();

    // 3. Continuous contention: core wins four cycles, coprocessor the fifth.
    core_req = 1'b1; core_we = 1'b0; core_addr = 64'h40;
    cop_req = 1'b1; cop_we = 1'b0; cop_addr = 15'h48;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("t3_cop_gnt_pattern", cop_gnt, (i % 5) == 4);
      cycle();
    end
    idle();
    cycle();

    // 4. Back-to-back reads: core @0x8 then coprocessor @0x10.
    core_req = 1'b1; core_we = 1'b0; core_addr = 64'h8;
    cycle();
    core_req = 1'b0;
    cop_req = 1'b1; cop_we = 1'b0; cop_addr = 15'h10;
    cycle();
    idle();
    cycle();

    // 5. Reset asserted the cycle after a granted coprocessor read.
    cop_req = 1'b1; cop_we = 1'b0; cop_addr = 15'h30;
    cycle(1'b1);
    idle();
    cycle();
    reset = 1'b1;
    cycle();

    // Same-address write by the core then read by the coprocessor in the next cycle.
    core_req = 1'b1; core_we = 1'b1; core_addr = 64'h7F8; core_wdata = 64'hDEADBEEF_01234567; core_byteen = 8'hFF;
    cycle();
    core_req = 1'b0;
    cop_req = 1'b1; cop_we = 1'b0; cop_addr = 15'h7FF8;
    cycle();
    idle();
    cycle();

    // 6. Zero-limit instance: coprocessor always wins while it requests.
    core_req = 1'b1; core_we = 1'b0; core_addr = 64'h0;
    cop_req = 1'b1; cop_we = 1'b0; cop_addr = 15'h8;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t6_lim0_gnt", z_gnt, 1'b1);
      check("t6_lim0_stall", z_stall, 1'b1);
      cycle();
    end
    cop_req = 1'b0;
    #1;
    check("t6_lim0_release", z_stall, 1'b0);
    cycle();
    idle();
    cycle();

    // Random traffic; requesters hold their fields until served.
    for (int n = 0; n < 400; n++) begin
      if (!(core_req && !last_egc)) begin
        core_req    = ($urandom_range(0, 3) != 0);
        core_we     = $urandom_range(0, 1);
        core_addr   = {$urandom, 21'($urandom), 3'($urandom_range(0, 7)), 3'($urandom)};
        core_wdata  = {$urandom, $urandom};
        core_byteen = 8'($urandom);
      end
      if (!(cop_req && !last_egp)) begin
        cop_req    = ($urandom_range(0, 2) != 0);
        cop_we     = $urandom_range(0, 1);
        cop_addr   = {4'($urandom), 5'd0, 3'($urandom_range(0, 7)), 3'($urandom)};
        cop_wdata  = {$urandom, $urandom};
        cop_byteen = 8'($urandom);
      end
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
